fpu_prenorm_fmac: RTL and testbench

FPU_PRENORM_FMAC -- requirements
Module: fpu_prenorm_fmac

---
 rtl/fpu_defs_fmac.sv | 49 ++++
 rtl/fpu_unpack_fmac.sv | 34 +++
 rtl/fpu_prenorm_fmac.sv | 132 +++++++++++++
 tb/tb_fpu_prenorm_fmac.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_defs_fmac.sv
// Shared constants and types for the FMA pre-normalisation front end.
// Operand class flags and the two pipeline-stage payload bundles.
package fpu_defs_fmac;

    localparam int unsigned C_OP        = 32;
    localparam int unsigned C_EXP       = 8;
    localparam int unsigned C_MANT      = 23;
    localparam int unsigned C_BIAS      = 127;
    localparam int unsigned C_RM        = 3;
    localparam int unsigned C_SHIFT_MAX = 74;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
        logic den;
    } op_class_t;

    typedef struct packed {
        logic             sign;
        logic [C_EXP-1:0] exp;
        logic [C_MANT:0]  mant;
        op_class_t        cls;
    } op_unpk_t;

    typedef struct packed {
        op_unpk_t        a;
        op_unpk_t        b;
        op_unpk_t        c;
        logic [C_RM-1:0] rm;
    } s1_t;

    typedef struct packed {
        logic [C_MANT:0]    mant_a;
        logic [C_MANT:0]    mant_b;
        logic [C_MANT:0]    mant_c;
        logic [C_EXP-1:0]   exp_a;
        logic signed [9:0]  exp_prod;
        logic [6:0]         shift;
        logic               sign_amt;
        logic               sign_a;
        logic               sign_prod;
        op_class_t          cls_a;
        op_class_t          cls_b;
        op_class_t          cls_c;
        logic [C_RM-1:0]    rm;
    } s2_t;

endpackage

// File: rtl/fpu_unpack_fmac.sv
// Splits one single-precision operand into sign, effective exponent,
// mantissa with hidden bit, and its class flags.
module fpu_unpack_fmac
    import fpu_defs_fmac::*;
(
    input  logic [C_OP-1:0] Operand_DI,
    output op_unpk_t        Unpk_DO
);

    logic [C_EXP-1:0] exp_raw;
    logic [C_MANT-1:0] frac;
    logic e_max;
    logic e_zero;
    logic f_nz;

    assign exp_raw = Operand_DI[C_OP-2 -: C_EXP];
    assign frac    = Operand_DI[C_MANT-1:0];
    assign e_max   = &exp_raw;
    assign e_zero  = ~|exp_raw;
    assign f_nz    = |frac;

    always_comb begin
        Unpk_DO          = '0;
        Unpk_DO.sign     = Operand_DI[C_OP-1];
        // Denormals share exponent 1 with the smallest normal.
        Unpk_DO.exp      = e_zero ? C_EXP'(1) : exp_raw;
        Unpk_DO.mant     = {~e_zero, frac};
        Unpk_DO.cls.nan  = e_max & f_nz;
        Unpk_DO.cls.inf  = e_max & ~f_nz;
        Unpk_DO.cls.zero = e_zero & ~f_nz;
        Unpk_DO.cls.den  = e_zero & f_nz;
    end

endmodule

// File: rtl/fpu_prenorm_fmac.sv
// Two-stage FMA pre-normaliser for a + b*c: unpack in S1, product
// exponent and addend alignment shift in S2, valid/ready per stage.
module fpu_prenorm_fmac
    import fpu_defs_fmac::*;
(
    input  logic              Clk_CI,
    input  logic              Rst_RI,
    input  logic [C_OP-1:0]   Operand_a_DI,
    input  logic [C_OP-1:0]   Operand_b_DI,
    input  logic [C_OP-1:0]   Operand_c_DI,
    input  logic [C_RM-1:0]   RM_SI,
    input  logic              Valid_SI,
    output logic              Ready_SO,
    output logic              Valid_SO,
    input  logic              Ready_SI,
    output logic [C_MANT:0]   Mant_a_DO,
    output logic [C_MANT:0]   Mant_b_DO,
    output logic [C_MANT:0]   Mant_c_DO,
    output logic [C_EXP-1:0]  Exp_a_DO,
    output logic signed [9:0] Exp_prod_DO,
    output logic [6:0]        Shift_amt_DO,
    output logic              Sign_amt_DO,
    output logic              Sign_a_DO,
    output logic              Sign_prod_DO,
    output logic              NaN_a_SO,
    output logic              NaN_b_SO,
    output logic              NaN_c_SO,
    output logic              Inf_a_SO,
    output logic              Inf_b_SO,
    output logic              Inf_c_SO,
    output logic              Zero_a_SO,
    output logic              Zero_b_SO,
    output logic              Zero_c_SO,
    output logic              DeN_a_SO,
    output logic              DeN_b_SO,
    output logic              DeN_c_SO,
    output logic [C_RM-1:0]   RM_SO
);

    op_unpk_t ua, ub, uc;
    s1_t s1_q, s1_d;
    s2_t s2_q, s2_d, s2_new;
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_ready, s2_ready;
    logic s1_load, s2_load;
    logic signed [9:0]  ep;
    logic signed [10:0] raw;
    logic raw_le0, raw_gt;

    fpu_unpack_fmac u_unp_a (.Operand_DI(Operand_a_DI), .Unpk_DO(ua));
    fpu_unpack_fmac u_unp_b (.Operand_DI(Operand_b_DI), .Unpk_DO(ub));
    fpu_unpack_fmac u_unp_c (.Operand_DI(Operand_c_DI), .Unpk_DO(uc));

    assign s2_ready = ~s2_valid_q | Ready_SI;
    assign s1_ready = ~s1_valid_q | s2_ready;
    assign s1_load  = Valid_SI & s1_ready;
    assign s2_load  = s1_valid_q & s2_ready;

    assign s1_valid_d = s1_load | (s1_valid_q & ~s2_ready);
    assign s2_valid_d = s2_load | (s2_valid_q & ~Ready_SI);
    assign s1_d = s1_load ? '{a: ua, b: ub, c: uc, rm: RM_SI} : s1_q;
    assign s2_d = s2_load ? s2_new : s2_q;

    always_comb begin
        ep = $signed({2'b00, s1_q.b.exp}) + $signed({2'b00, s1_q.c.exp})
           - $signed(10'(C_BIAS));
        raw = {ep[9], ep} - $signed({3'b000, s1_q.a.exp})
            + $signed(11'(C_MANT + 3));
        raw_le0 = raw[10] | (raw == '0);
        raw_gt  = raw > $signed(11'(C_SHIFT_MAX));

        s2_new           = '0;
        s2_new.mant_a    = s1_q.a.mant;
        s2_new.mant_b    = s1_q.b.mant;
        s2_new.mant_c    = s1_q.c.mant;
        s2_new.exp_a     = s1_q.a.exp;
        s2_new.exp_prod  = ep;
        s2_new.shift     = raw_le0 ? 7'd0 :
                           raw_gt  ? 7'(C_SHIFT_MAX) : raw[6:0];
        // A zero product leaves the (finite) addend as the answer.
        s2_new.sign_amt  = raw_le0
                         | ((s1_q.b.cls.zero | s1_q.c.cls.zero)
                            & ~(s1_q.a.cls.nan | s1_q.a.cls.inf));
        s2_new.sign_a    = s1_q.a.sign;
        s2_new.sign_prod = s1_q.b.sign ^ s1_q.c.sign;
        s2_new.cls_a     = s1_q.a.cls;
        s2_new.cls_b     = s1_q.b.cls;
        s2_new.cls_c     = s1_q.c.cls;
        s2_new.rm        = s1_q.rm;
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign Ready_SO     = s1_ready;
    assign Valid_SO     = s2_valid_q;
    assign Mant_a_DO    = s2_q.mant_a;
    assign Mant_b_DO    = s2_q.mant_b;
    assign Mant_c_DO    = s2_q.mant_c;
    assign Exp_a_DO     = s2_q.exp_a;
    assign Exp_prod_DO  = s2_q.exp_prod;
    assign Shift_amt_DO = s2_q.shift;
    assign Sign_amt_DO  = s2_q.sign_amt;
    assign Sign_a_DO    = s2_q.sign_a;
    assign Sign_prod_DO = s2_q.sign_prod;
    assign NaN_a_SO     = s2_q.cls_a.nan;
    assign NaN_b_SO     = s2_q.cls_b.nan;
    assign NaN_c_SO     = s2_q.cls_c.nan;
    assign Inf_a_SO     = s2_q.cls_a.inf;
    assign Inf_b_SO     = s2_q.cls_b.inf;
    assign Inf_c_SO     = s2_q.cls_c.inf;
    assign Zero_a_SO    = s2_q.cls_a.zero;
    assign Zero_b_SO    = s2_q.cls_b.zero;
    assign Zero_c_SO    = s2_q.cls_c.zero;
    assign DeN_a_SO     = s2_q.cls_a.den;
    assign DeN_b_SO     = s2_q.cls_b.den;
    assign DeN_c_SO     = s2_q.cls_c.den;
    assign RM_SO        = s2_q.rm;

endmodule

// File: tb/tb_fpu_prenorm_fmac.sv
// Randomised and directed checks of fpu_prenorm_fmac against an
// arithmetic reference model with an in-order scoreboard.
module tb_fpu_prenorm_fmac;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] op_a = '0, op_b = '0, op_c = '0;
    logic [2:0]  rm_i = '0;
    logic        vin = 1'b0, rdy = 1'b0;
    logic        rdy_o, vout;
    logic [23:0] ma, mb, mc;
    logic [7:0]  ea;
    logic signed [9:0] ep;
    logic [6:0]  sh;
    logic        samt, sa, sp;
    logic        na, nb, nc, ia, ib, ic, za, zb, zc, da, db, dc;
    logic [2:0]  rm_o;

    int n_vec = 0;
    int n_err = 0;
    logic [127:0] sb[$];

    fpu_prenorm_fmac dut (
        .Clk_CI(clk), .Rst_RI(rst),
        .Operand_a_DI(op_a), .Operand_b_DI(op_b), .Operand_c_DI(op_c),
        .RM_SI(rm_i), .Valid_SI(vin), .Ready_SO(rdy_o),
        .Valid_SO(vout), .Ready_SI(rdy),
        .Mant_a_DO(ma), .Mant_b_DO(mb), .Mant_c_DO(mc),
        .Exp_a_DO(ea), .Exp_prod_DO(ep), .Shift_amt_DO(sh),
        .Sign_amt_DO(samt), .Sign_a_DO(sa), .Sign_prod_DO(sp),
        .NaN_a_SO(na), .NaN_b_SO(nb), .NaN_c_SO(nc),
        .Inf_a_SO(ia), .Inf_b_SO(ib), .Inf_c_SO(ic),
        .Zero_a_SO(za), .Zero_b_SO(zb), .Zero_c_SO(zc),
        .DeN_a_SO(da), .DeN_b_SO(db), .DeN_c_SO(dc),
        .RM_SO(rm_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {nan, inf, zero, den}
    function automatic logic [3:0] cls(input logic [31:0] x);
        int e = int'(x[30:23]);
        int f = int'(x[22:0]);
        return {e == 255 && f != 0, e == 255 && f == 0,
                e == 0 && f == 0, e == 0 && f != 0};
    endfunction

    function automatic logic [127:0] model(input logic [31:0] a, b, c,
                                           input logic [2:0] rm);
        int xa = (a[30:23] == 0) ? 1 : int'(a[30:23]);
        int xb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
        int xc = (c[30:23] == 0) ? 1 : int'(c[30:23]);
        int prod = xb + xc - 127;
        int raw = prod - xa + 26;
        int shv;
        logic [3:0] ka = cls(a), kb = cls(b), kc = cls(c);
        logic [23:0] m_a = {a[30:23] != 0, a[22:0]};
        logic [23:0] m_b = {b[30:23] != 0, b[22:0]};
        logic [23:0] m_c = {c[30:23] != 0, c[22:0]};
        logic [9:0] p10 = prod[9:0];
        logic amt;
        shv = (raw <= 0) ? 0 : (raw > 74) ? 74 : raw;
        amt = (raw <= 0) || ((kb[1] || kc[1]) && !(ka[3] || ka[2]));
        return {m_a, m_b, m_c, 8'(xa), p10, 7'(shv), amt,
                a[31], b[31] ^ c[31],
                ka[3], kb[3], kc[3], ka[2], kb[2], kc[2],
                ka[1], kb[1], kc[1], ka[0], kb[0], kc[0], rm, 13'd0};
    endfunction

    function automatic logic [127:0] obs();
        return {ma, mb, mc, ea, ep, sh, samt, sa, sp,
                na, nb, nc, ia, ib, ic, za, zb, zc, da, db, dc,
                rm_o, 13'd0};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0] e;
        logic [22:0] f = 23'($urandom);
        case ($urandom_range(0, 7))
            0: begin e = 8'd0;   f = '0; end
            1: begin e = 8'd0;   f = f | 23'd1; end
            2: begin e = 8'd255; f = '0; end
            3: begin e = 8'd255; f = f | 23'd1; end
            4: e = 8'($urandom_range(100, 154));
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom), e, f};
    endfunction

    task automatic step(input logic v, input logic [31:0] a, b, c,
                        input logic [2:0] rm, input logic r,
                        output logic acc, output logic pop);
        @(negedge clk);
        vin = v; op_a = a; op_b = b; op_c = c; rm_i = rm; rdy = r;
        #1;
        acc = v & rdy_o;
        pop = vout & r;
        if (pop) begin
            if (sb.size() == 0) chk("spurious_out", 128'(vout), 128'd0);
            else chk("out", obs(), sb.pop_front());
        end
        if (acc) sb.push_back(model(a, b, c, rm));
    endtask

    task automatic wait_out(output int lat);
        logic acc, pop;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, '0, '0, '0, '0, 1'b1, acc, pop);
            if (pop) begin
                lat = i;
                return;
            end
        end
        chk("out_timeout", 128'(vout), 128'd1);
    endtask

    initial begin
        logic acc, pop;
        int lat;
        logic [127:0] snap;
        logic [31:0] ta[3];

        #2;
        chk("rst_valid", 128'(vout), 128'd0);
        chk("rst_ready", 128'(rdy_o), 128'd1);
        chk("rst_payload", obs(), 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        step(1'b1, 32'h3F800000, 32'h40000000, 32'h40400000, 3'd1, 1'b1,
             acc, pop);
        chk("d1_acc", 128'(acc), 128'd1);
        wait_out(lat);
        chk("d1_lat", 128'(lat), 128'd2);
        chk("d1_expa", 128'(ea), 128'd127);
        chk("d1_expp", 128'(ep), 128'd129);
        chk("d1_shift", 128'(sh), 128'd28);
        chk("d1_samt", 128'(samt), 128'd0);
        chk("d1_flags", 128'({na, nb, nc, ia, ib, ic, za, zb, zc,
                              da, db, dc}), 128'd0);

        step(1'b1, 32'h7F000000, 32'h3F800000, 32'h3F800000, 3'd2, 1'b1,
             acc, pop);
        wait_out(lat);
        chk("d2_samt", 128'(samt), 128'd1);
        chk("d2_shift", 128'(sh), 128'd0);

        step(1'b1, 32'h00000001, 32'h7FC00000, 32'hFF800000, 3'd3, 1'b1,
             acc, pop);
        wait_out(lat);
        chk("d3_den_a", 128'(da), 128'd1);
        chk("d3_expa", 128'(ea), 128'd1);
        chk("d3_manta", 128'(ma), 128'h000001);
        chk("d3_nan_b", 128'(nb), 128'd1);
        chk("d3_inf_c", 128'(ic), 128'd1);
        chk("d3_sprod", 128'(sp), 128'd1);

        // Backpressure: third transaction must stall with S1 and S2 full.
        for (int i = 0; i < 3; i++) ta[i] = rand_op();
        step(1'b1, ta[0], ta[1], ta[2], 3'd0, 1'b0, acc, pop);
        chk("bp_acc0", 128'(acc), 128'd1);
        step(1'b1, ta[1], ta[2], ta[0], 3'd1, 1'b0, acc, pop);
        chk("bp_acc1", 128'(acc), 128'd1);
        step(1'b1, ta[2], ta[0], ta[1], 3'd2, 1'b0, acc, pop);
        chk("bp_ready_low", 128'(rdy_o), 128'd0);
        snap = obs();
        step(1'b1, ta[2], ta[0], ta[1], 3'd2, 1'b0, acc, pop);
        chk("bp_stable", obs(), snap);
        chk("bp_valid", 128'(vout), 128'd1);
        for (int i = 0; i < 10 && !acc; i++)
            step(1'b1, ta[2], ta[0], ta[1], 3'd2, 1'b1, acc, pop);
        chk("bp_acc2", 128'(acc), 128'd1);
        for (int i = 0; i < 10 && sb.size() != 0; i++)
            step(1'b0, '0, '0, '0, '0, 1'b1, acc, pop);
        chk("bp_drained", 128'(sb.size()), 128'd0);

        // Asynchronous reset with two transactions in flight.
        step(1'b1, rand_op(), rand_op(), rand_op(), 3'd4, 1'b0, acc, pop);
        step(1'b1, rand_op(), rand_op(), rand_op(), 3'd5, 1'b0, acc, pop);
        @(posedge clk);
        #2;
        chk("pre_rst_valid", 128'(vout), 128'd1);
        rst = 1'b1;
        #1;
        chk("arst_valid", 128'(vout), 128'd0);
        chk("arst_ready", 128'(rdy_o), 128'd1);
        sb.delete();
        vin = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 32'h3F800000, 32'h40000000, 32'h40400000, 3'd6, 1'b1,
             acc, pop);
        wait_out(lat);
        chk("post_rst_lat", 128'(lat), 128'd2);

        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 3) != 0), rand_op(), rand_op(),
                 rand_op(), 3'($urandom), 1'($urandom_range(0, 2) != 0),
                 acc, pop);
        for (int i = 0; i < 20 && sb.size() != 0; i++)
            step(1'b0, '0, '0, '0, '0, 1'b1, acc, pop);
        chk("final_drain", 128'(sb.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
